ex_div_ctrl: RTL

- Multi-cycle integer divide controller inside the EX stage.
- Accepts div.w/mod.w/div.wu/mod.wu from the EX operand bus and runs an iterative radix-2 restoring division over XLEN cycles.
- Drives EX ready_go low until the result is final and holds the result until MEM accepts it.
- Non-divide instructions pass with zero added latency.

---
 rtl/ex_div_ctrl_pkg.sv | 35 +++
 rtl/ex_div_ctrl_step.sv | 24 ++
 rtl/ex_div_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// Shared encodings for the EX-stage iterative divider.
package ex_div_ctrl_pkg;

  localparam int unsigned DIV_XLEN  = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_W  = 2'b00,
    MOD_W  = 2'b01,
    DIV_WU = 2'b10,
    MOD_WU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // Per-operation context captured at accept time.
  typedef struct packed {
    logic    q_neg;
    logic    r_neg;
    div_op_e op;
  } div_ctx_t;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV_W) || (op == MOD_W);
  endfunction

  function automatic logic op_is_mod(input div_op_e op);
    return (op == MOD_W) || (op == MOD_WU);
  endfunction

endpackage

// File: rtl/ex_div_ctrl_step.sv
// Single combinational radix-2 restoring division step.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            msb_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_c,
  output logic            q_bit_c
);

  // Partial remainder keeps the bit shifted out of rem so divisors >= 2^(XLEN-1) still work.
  logic [XLEN:0] partial_c;
  logic [XLEN:0] divisor_ext_c;

  // Trial subtract and restore.
  always_comb begin
    partial_c     = {rem_i, msb_i};
    divisor_ext_c = {1'b0, divisor_i};
    q_bit_c       = (partial_c >= divisor_ext_c);
    rem_c         = q_bit_c ? XLEN'(partial_c - divisor_ext_c) : partial_c[XLEN-1:0];
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// EX-stage multi-cycle divide/modulo controller; stalls EX until the result is final.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = DIV_XLEN,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ex_valid,
  input  logic            div_en,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] div_src1,
  input  logic [XLEN-1:0] div_src2,
  input  logic            MEM_allow_in,
  input  logic            flush,
  output logic            div_ready_go,
  output logic [XLEN-1:0] div_result,
  output logic            div_busy
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  dq_q, dq_d;        // dividend shifts out the top, quotient shifts in the bottom
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  result_q, result_d;
  div_ctx_t         ctx_q, ctx_d;
  logic             busy_q, busy_d;

  logic [XLEN-1:0]  step_rem_c;
  logic             step_q_c;
  div_op_e          op_in_c;
  logic             op_signed_c;
  logic [XLEN-1:0]  abs1_c, abs2_c;
  logic [XLEN-1:0]  quo_fin_c, quo_fix_c, rem_fix_c;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .msb_i     (dq_q[XLEN-1]),
    .divisor_i (dvs_q),
    .rem_c     (step_rem_c),
    .q_bit_c   (step_q_c)
  );

  // Operand magnitudes and sign-corrected results; 0x80000000 negates to itself = 2^31 unsigned.
  always_comb begin
    op_in_c     = div_op_e'(div_op);
    op_signed_c = op_is_signed(op_in_c);
    abs1_c      = (op_signed_c && div_src1[XLEN-1]) ? (~div_src1 + XLEN'(1)) : div_src1;
    abs2_c      = (op_signed_c && div_src2[XLEN-1]) ? (~div_src2 + XLEN'(1)) : div_src2;
    quo_fin_c   = {dq_q[XLEN-2:0], step_q_c};
    quo_fix_c   = ctx_q.q_neg ? (~quo_fin_c + XLEN'(1)) : quo_fin_c;
    rem_fix_c   = ctx_q.r_neg ? (~step_rem_c + XLEN'(1)) : step_rem_c;
  end

  // Next-state, datapath updates and the EX stall.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dq_d         = dq_q;
    dvs_d        = dvs_q;
    rem_d        = rem_q;
    ctx_d        = ctx_q;
    result_d     = result_q;
    busy_d       = 1'b0;
    div_ready_go = 1'b1;

    case (state_q)
      IDLE: begin
        if (ex_valid && div_en && !flush) begin
          state_d     = CALC;
          cnt_d       = '0;
          dq_d        = abs1_c;
          dvs_d       = abs2_c;
          rem_d       = '0;
          ctx_d.q_neg = op_signed_c && (div_src1[XLEN-1] ^ div_src2[XLEN-1]);
          ctx_d.r_neg = op_signed_c && div_src1[XLEN-1];
          ctx_d.op    = op_in_c;
        end
      end
      CALC: begin
        rem_d = step_rem_c;
        dq_d  = quo_fin_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d  = DONE;
          result_d = op_is_mod(ctx_q.op) ? rem_fix_c : quo_fix_c;
        end
      end
      DONE: begin
        if (MEM_allow_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    busy_d       = (state_d != IDLE);
    div_ready_go = !ex_valid || !div_en || (state_q == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dq_q     <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      ctx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_q     <= dq_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      ctx_q    <= ctx_d;
      result_q <= result_d;
      busy_q   <= busy_d;
    end
  end

  assign div_result = result_q;
  assign div_busy   = busy_q;

endmodule
